// File: rtl/multichannel_fir_filter.sv
// Time-multiplexed FIR: NUM_CH channels share one MAC, runtime-loadable coefficients,
// rounded/saturated outputs and a sticky overrun flag for ticks arriving while busy.

module fir_delay_lane #(
  parameter int DATA_W   = 24,
  parameter int NUM_TAPS = 21
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             shift_en,
  input  logic [DATA_W-1:0]                sample,
  output logic [NUM_TAPS-1:0][DATA_W-1:0]  taps
);
  always_ff @(posedge clk_i) begin
    if (reset_i)       taps <= '0;
    else if (shift_en) taps <= {taps[NUM_TAPS-2:0], sample};
  end
endmodule

module multichannel_fir_filter #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 24,
  parameter int COEFF_W   = 24,
  parameter int NUM_TAPS  = 21,
  parameter int OUT_SHIFT = 23
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          tick_i,
  input  logic [NUM_CH*DATA_W-1:0]      data_i,
  input  logic                          coeff_we_i,
  input  logic [$clog2(NUM_TAPS)-1:0]   coeff_addr_i,
  input  logic [COEFF_W-1:0]            coeff_data_i,
  output logic [NUM_CH*DATA_W-1:0]      data_o,
  output logic                          tick_o,
  output logic                          busy_o,
  output logic                          overrun_o
);
  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = DATA_W + COEFF_W;
  localparam int ACC_W  = PROD_W + TAP_W;
  localparam logic signed [ACC_W:0] HALF    = {{ACC_W{1'b0}}, 1'b1} << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+1-DATA_W){1'b0}}, 1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t                                   state;
  logic [CH_W-1:0]                          ch;
  logic [TAP_W-1:0]                         tap;
  logic signed [ACC_W-1:0]                  acc;
  logic [NUM_TAPS-1:0][COEFF_W-1:0]         coeff;
  logic [NUM_CH-1:0][NUM_TAPS-1:0][DATA_W-1:0] taps;
  logic [NUM_CH-1:0][DATA_W-1:0]            shadow, shadow_nxt;
  logic                                     accept;
  logic signed [DATA_W-1:0]                 mac_sample;
  logic signed [COEFF_W-1:0]                mac_coeff;
  logic signed [PROD_W-1:0]                 prod;
  logic signed [ACC_W:0]                    rsum, rshift;
  logic signed [DATA_W-1:0]                 rsat;

  assign accept = (state == IDLE) && tick_i;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_lane
      fir_delay_lane #(.DATA_W(DATA_W), .NUM_TAPS(NUM_TAPS)) u_lane (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .shift_en (accept),
        .sample   (data_i[c*DATA_W +: DATA_W]),
        .taps     (taps[c])
      );
    end
  endgenerate

  assign mac_sample = taps[ch][tap];
  assign mac_coeff  = coeff[tap];
  assign prod       = mac_sample * mac_coeff;

  // Round half up, then clamp into the signed output range.
  always_comb begin
    rsum   = {acc[ACC_W-1], acc} + HALF;
    rshift = rsum >>> OUT_SHIFT;
    rsat   = rshift[DATA_W-1:0];
    if (rshift > SAT_MAX)      rsat = SAT_MAX[DATA_W-1:0];
    else if (rshift < SAT_MIN) rsat = SAT_MIN[DATA_W-1:0];
    shadow_nxt     = shadow;
    shadow_nxt[ch] = rsat;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state     <= IDLE;
      ch        <= '0;
      tap       <= '0;
      acc       <= '0;
      coeff     <= '0;
      shadow    <= '0;
      data_o    <= '0;
      tick_o    <= 1'b0;
      busy_o    <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (tick_i && state != IDLE) overrun_o <= 1'b1;
      case (state)
        IDLE: begin
          // Write lands before a same-cycle tick, so MAC sees the new value.
          if (coeff_we_i && ({1'b0, coeff_addr_i} < (TAP_W+1)'(NUM_TAPS)))
            coeff[coeff_addr_i] <= coeff_data_i;
          if (tick_i) begin
            ch     <= '0;
            tap    <= '0;
            acc    <= '0;
            busy_o <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (tap == TAP_W'(NUM_TAPS - 1)) state <= ROUND;
          else                             tap   <= tap + 1'b1;
        end
        ROUND: begin
          shadow <= shadow_nxt;
          acc    <= '0;
          tap    <= '0;
          if (ch == CH_W'(NUM_CH - 1)) begin
            data_o <= shadow_nxt;
            tick_o <= 1'b1;
            state  <= OUT;
          end else begin
            ch    <= ch + 1'b1;
            state <= MAC;
          end
        end
        OUT: begin
          tick_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
